// File: rtl/synth_pkg.sv
// synth_pkg: definitions shared by the tone-path control blocks.
// Contents:
//   - step-word field layout {rest, wave[1:0], octave[1:0], note[3:0]}
//   - waveform codes and the rest word
//   - sequencer FSM state encoding
//   - the minimum step length
//   - step-word decode helpers
package synth_pkg;

   localparam int STEP_W    = 9;
   localparam int NOTE_LSB  = 0;
   localparam int NOTE_W    = 4;
   localparam int OCT_LSB   = 4;
   localparam int OCT_W     = 2;
   localparam int WAVE_LSB  = 6;
   localparam int WAVE_W    = 2;
   localparam int REST_BIT  = 8;
   localparam int NOTE_SW_W = 11;

   localparam logic [WAVE_W-1:0] WAVE_SINE = 2'd0;
   localparam logic [WAVE_W-1:0] WAVE_TRI  = 2'd1;
   localparam logic [WAVE_W-1:0] WAVE_SQR  = 2'd2;
   localparam logic [WAVE_W-1:0] WAVE_SAW  = 2'd3;

   localparam logic [STEP_W-1:0] REST_WORD = 9'h100;

   localparam int unsigned MIN_STEP_LEN = 8;

   typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} seq_state_t;

   // A step sounds only when the rest flag is clear and the note maps to
   // one of the 11 note switches; notes 11..15 behave like a rest.
   function automatic logic step_sounds(input logic [STEP_W-1:0] w);
      return !w[REST_BIT] && (w[NOTE_LSB +: NOTE_W] <= 4'd10);
   endfunction

   function automatic logic [NOTE_SW_W-1:0] note_onehot(input logic [STEP_W-1:0] w);
      if (step_sounds(w))
         return NOTE_SW_W'(1) << w[NOTE_LSB +: NOTE_W];
      return '0;
   endfunction

endpackage

// File: rtl/note_sequencer_step_ram.sv
// step_ram: pattern register file for the note sequencer.
// Every entry resets to the rest word. Writes land on the clock edge;
// reads are combinational, so a read and a write to the same entry in
// the same cycle return the old word.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   wr_en     write strobe
//   wr_addr   entry to write
//   wr_data   step word to store
//   rd_addr   entry to read
//   rd_data   stored step word (combinational)
module step_ram
   import synth_pkg::*;
#(
   parameter int STEPS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [2:0]        wr_addr,
   input  logic [STEP_W-1:0] wr_data,
   input  logic [2:0]        rd_addr,
   output logic [STEP_W-1:0] rd_data
);

   localparam int AW = (STEPS > 1) ? $clog2(STEPS) : 1;

   logic [STEP_W-1:0] r_mem [STEPS];
   logic [AW-1:0]     w_wa;
   logic [AW-1:0]     w_ra;

   assign w_wa = wr_addr[AW-1:0];
   assign w_ra = rd_addr[AW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STEPS; i++)
            r_mem[i] <= REST_WORD;
      end else if (wr_en) begin
         r_mem[w_wa] <= wr_data;
      end
   end

   assign rd_data = r_mem[w_ra];

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: autonomous step sequencer for the tone datapath.
// Plays steps 0..seq_len from the pattern RAM, each lasting
// max(tempo_div, 8) clocks, and presents note switches, octave, waveform
// and gate for each step.
// Build option NOTE_SEQUENCER_GAP_EN: drop the gate for the last L/8
// cycles of every step (staccato). Without it the gate is held across
// consecutive sounding steps (legato).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   run        1 = play, 0 = stop (returns to IDLE next edge)
//   seq_len    index of the last step played
//   tempo_div  clocks per step, sampled at each step load
//   wr_en, wr_addr, wr_data   pattern write port
//   note_sw    one-hot note code (bit n-1 = sw[n])
//   octave     octave for the divider
//   wave_sel   0 sine, 1 triangle, 2 square, 3 saw
//   gate       generator enable
//   step_idx   step currently selected
//   step_tick  one-cycle pulse with each newly loaded step
module note_sequencer
   import synth_pkg::*;
#(
   parameter int STEPS   = 8,
   parameter int TEMPO_W = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [2:0]           seq_len,
   input  logic [TEMPO_W-1:0]   tempo_div,
   input  logic                 wr_en,
   input  logic [2:0]           wr_addr,
   input  logic [STEP_W-1:0]    wr_data,
   output logic [NOTE_SW_W-1:0] note_sw,
   output logic [OCT_W-1:0]     octave,
   output logic [WAVE_W-1:0]    wave_sel,
   output logic                 gate,
   output logic [2:0]           step_idx,
   output logic                 step_tick
);

   seq_state_t           r_state;
   logic [TEMPO_W-1:0]   r_cnt;
   logic [TEMPO_W-1:0]   r_last;
   logic [2:0]           r_idx;
   logic [NOTE_SW_W-1:0] r_note_sw;
   logic [OCT_W-1:0]     r_octave;
   logic [WAVE_W-1:0]    r_wave;
   logic                 r_gate;
   logic                 r_tick;

   logic [STEP_W-1:0]    w_rd;
   logic [TEMPO_W-1:0]   w_len;
   logic [2:0]           w_next_idx;
   logic                 w_at_end;

   step_ram #(.STEPS(STEPS)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (r_idx),
      .rd_data (w_rd)
   );

   assign w_len = (tempo_div < TEMPO_W'(MIN_STEP_LEN)) ? TEMPO_W'(MIN_STEP_LEN) : tempo_div;

   // The counter covers the PLAY/GAP cycles only (0..L-2); the LOAD cycle
   // makes up the remaining cycle, so LOAD-to-LOAD is exactly L.
   assign w_at_end = (r_cnt == r_last);

   // Also wrap at the RAM depth so a seq_len beyond STEPS-1 stays in range.
   assign w_next_idx = ((r_idx >= seq_len) || (r_idx == 3'(STEPS - 1))) ? 3'd0 : r_idx + 3'd1;

`ifdef NOTE_SEQUENCER_GAP_EN
   logic [TEMPO_W-1:0] r_gap_at;
   logic [TEMPO_W-1:0] w_gap_at;

   assign w_gap_at = w_len - (w_len >> 3) - TEMPO_W'(1);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_last    <= '0;
         r_idx     <= '0;
         r_note_sw <= '0;
         r_octave  <= '0;
         r_wave    <= '0;
         r_gate    <= 1'b0;
         r_tick    <= 1'b0;
`ifdef NOTE_SEQUENCER_GAP_EN
         r_gap_at  <= '0;
`endif
      end else if (!run) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_note_sw <= '0;
         r_octave  <= '0;
         r_wave    <= '0;
         r_gate    <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_tick  <= 1'b0;
               r_state <= LOAD;
            end
            LOAD: begin
               r_note_sw <= note_onehot(w_rd);
               r_octave  <= w_rd[OCT_LSB +: OCT_W];
               r_wave    <= w_rd[WAVE_LSB +: WAVE_W];
               r_gate    <= step_sounds(w_rd);
               r_tick    <= 1'b1;
               r_cnt     <= '0;
               r_last    <= w_len - TEMPO_W'(2);
`ifdef NOTE_SEQUENCER_GAP_EN
               r_gap_at  <= w_gap_at;
`endif
               r_state   <= PLAY;
            end
            PLAY: begin
               r_tick <= 1'b0;
               r_cnt  <= r_cnt + TEMPO_W'(1);
               if (w_at_end) begin
                  r_idx   <= w_next_idx;
                  r_state <= LOAD;
`ifdef NOTE_SEQUENCER_GAP_EN
                  // Shortest steps put the gap start on the last PLAY
                  // cycle; the gate still has to drop for the LOAD cycle.
                  r_gate  <= 1'b0;
`endif
               end
`ifdef NOTE_SEQUENCER_GAP_EN
               else if (r_cnt == r_gap_at) begin
                  r_gate  <= 1'b0;
                  r_state <= GAP;
               end
`endif
            end
            GAP: begin
               r_tick <= 1'b0;
               r_cnt  <= r_cnt + TEMPO_W'(1);
               if (w_at_end) begin
                  r_idx   <= w_next_idx;
                  r_state <= LOAD;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign note_sw   = r_note_sw;
   assign octave    = r_octave;
   assign wave_sel  = r_wave;
   assign gate      = r_gate;
   assign step_idx  = r_idx;
   assign step_tick = r_tick;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

   logic        clk;
   logic        rst;
   logic        run;
   logic [2:0]  seq_len;
   logic [23:0] tempo_div;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [8:0]  wr_data;
   logic [10:0] note_sw;
   logic [1:0]  octave;
   logic [1:0]  wave_sel;
   logic        gate;
   logic [2:0]  step_idx;
   logic        step_tick;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [10:0] note;
      logic [1:0]  oct;
      logic [1:0]  wave;
      logic        gate;
      logic [2:0]  idx;
      int          period;
   } exp_t;

   exp_t sb[$];

   note_sequencer #(.STEPS(8), .TEMPO_W(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .seq_len   (seq_len),
      .tempo_div (tempo_div),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .note_sw   (note_sw),
      .octave    (octave),
      .wave_sel  (wave_sel),
      .gate      (gate),
      .step_idx  (step_idx),
      .step_tick (step_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [10:0] n, input logic [1:0] o, input logic [1:0] w,
                       input logic g, input logic [2:0] i, input int p);
      exp_t e;
      e.note = n; e.oct = o; e.wave = w; e.gate = g; e.idx = i; e.period = p;
      sb.push_back(e);
   endtask

   // Wait (bounded) for the next step_tick, then compare against the
   // oldest scoreboard entry. Period is counted in negedges from the call.
   task automatic check_tick(input string tag);
      exp_t e;
      int   n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!step_tick && n < 300);
      chk({tag, "_sb_entry"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_tick"},   32'(step_tick), 32'd1);
         chk({tag, "_period"}, 32'(n),         32'(e.period));
         chk({tag, "_note"},   32'(note_sw),   32'(e.note));
         chk({tag, "_oct"},    32'(octave),    32'(e.oct));
         chk({tag, "_wave"},   32'(wave_sel),  32'(e.wave));
         chk({tag, "_gate"},   32'(gate),      32'(e.gate));
         chk({tag, "_idx"},    32'(step_idx),  32'(e.idx));
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [8:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   initial begin
      int errs;
      logic exp_g;
      rst       = 1'b1;
      run       = 1'b0;
      seq_len   = 3'd0;
      tempo_div = 24'd16;
      wr_en     = 1'b0;
      wr_addr   = 3'd0;
      wr_data   = 9'd0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_note", 32'(note_sw),   32'd0);
      chk("rst_oct",  32'(octave),    32'd0);
      chk("rst_wave", 32'(wave_sel),  32'd0);
      chk("rst_gate", 32'(gate),      32'd0);
      chk("rst_idx",  32'(step_idx),  32'd0);
      chk("rst_tick", 32'(step_tick), 32'd0);

      // run straight out of reset: entry 0 is the rest word
      rst = 1'b0;
      run = 1'b1;
      push(11'h000, 2'd0, 2'd0, 1'b0, 3'd0, 2);
      check_tick("start_rest");
      run = 1'b0;
      @(negedge clk);
      chk("stop_gate", 32'(gate), 32'd0);

      // single sounding step, tempo 16
      wr(3'd0, 9'h063);
      seq_len   = 3'd0;
      tempo_div = 24'd16;
      run       = 1'b1;
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 2);
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 16);
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 16);
      repeat (3) check_tick("step0_t16");
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      chk("runoff_note", 32'(note_sw), 32'd0);
      chk("runoff_gate", 32'(gate),    32'd0);
      chk("runoff_idx",  32'(step_idx), 32'd0);
      chk("runoff_oct",  32'(octave),  32'd0);

      // three steps, seq_len 2, then shrink seq_len while on step 2
      wr(3'd1, 9'h095);
      wr(3'd2, 9'h0FA);
      seq_len   = 3'd2;
      tempo_div = 24'd8;
      run       = 1'b1;
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 2);
      push(11'h020, 2'd1, 2'd2, 1'b1, 3'd1, 8);
      push(11'h400, 2'd3, 2'd3, 1'b1, 3'd2, 8);
      repeat (3) check_tick("seq3");
      seq_len = 3'd0;
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 8);
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 8);
      repeat (2) check_tick("shrink");

      // tempo clamp and tempo change granularity
      tempo_div = 24'd3;
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 8);
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 8);
      repeat (2) check_tick("tempo3");
      tempo_div = 24'd0;
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 8);
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 8);
      repeat (2) check_tick("tempo0");
      tempo_div = 24'd16;
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 8);
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 16);
      repeat (2) check_tick("tempo_chg");

      // out-of-range note acts as rest; write to the sounding step
      run = 1'b0;
      @(negedge clk);
      tempo_div = 24'd8;
      seq_len   = 3'd1;
      wr(3'd1, 9'h05C);
      run = 1'b1;
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 2);
      check_tick("restart");
      wr(3'd0, 9'h081);
      chk("hold_after_wr", 32'(note_sw), 32'h008);
      push(11'h000, 2'd1, 2'd1, 1'b0, 3'd1, 7);
      push(11'h002, 2'd0, 2'd2, 1'b1, 3'd0, 8);
      check_tick("note12");
      check_tick("wrap_new");

      // write landing on the LOAD edge of the same step reads the old word
      seq_len = 3'd0;
      repeat (7) @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 3'd0;
      wr_data = 9'h063;
      @(negedge clk);
      wr_en   = 1'b0;
      chk("coll_tick", 32'(step_tick), 32'd1);
      chk("coll_note", 32'(note_sw),   32'h002);
      chk("coll_wave", 32'(wave_sel),  32'd2);
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 8);
      check_tick("coll_next");

      // gate profile over one 64-cycle step
      tempo_div = 24'd64;
      push(11'h008, 2'd2, 2'd1, 1'b1, 3'd0, 8);
      check_tick("to_t64");
      errs = 0;
      for (int c = 1; c < 64; c++) begin
         @(negedge clk);
`ifdef NOTE_SEQUENCER_GAP_EN
         exp_g = (c < 56);
`else
         exp_g = 1'b1;
`endif
         if (gate !== exp_g || step_tick !== 1'b0 || note_sw !== 11'h008) errs++;
      end
      chk("gate_profile_errs", 32'(errs), 32'd0);
      @(negedge clk);
      chk("t64_tick", 32'(step_tick), 32'd1);
      chk("t64_gate", 32'(gate),      32'd1);

      // reset mid-play beats a concurrent write and clears the pattern
      rst     = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 3'd1;
      wr_data = 9'h063;
      @(negedge clk);
      chk("midrst_note", 32'(note_sw),   32'd0);
      chk("midrst_gate", 32'(gate),      32'd0);
      chk("midrst_oct",  32'(octave),    32'd0);
      chk("midrst_wave", 32'(wave_sel),  32'd0);
      chk("midrst_tick", 32'(step_tick), 32'd0);
      rst   = 1'b0;
      wr_en = 1'b0;
      push(11'h000, 2'd0, 2'd0, 1'b0, 3'd0, 2);
      check_tick("post_rst0");
      seq_len = 3'd1;
      push(11'h000, 2'd0, 2'd0, 1'b0, 3'd1, 64);
      check_tick("post_rst1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Step sequencer that drives the synthesizer's tone datapath without user input. It plays up to 8 programmable steps at a programmable tempo, and for each step it produces the one-hot note-switch code, octave, waveform code and a gate. It sits between the user/control logic and the frequency divider, waveform select and generator enables, which lets the lookup-table generators play melodies autonomously.

## Interface
Parameters:
- STEPS, 8: pattern depth; must be a power of two.
- TEMPO_W, 24: width of the tempo divisor.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- run  in  1  level; 1 = play, 0 = stop
- seq_len  in  3  index of the last step played (0..STEPS-1)
- tempo_div  in  TEMPO_W  clk cycles per step
- wr_en  in  1  pattern write strobe
- wr_addr  in  3  step to write
- wr_data  in  9  step word {rest, wave[1:0], octave[1:0], note[3:0]}
- note_sw  out  11  one-hot note code; bit n-1 corresponds to sw[n]
- octave  out  2  octave for the divider
- wave_sel  out  2  0 sine, 1 triangle, 2 square, 3 saw
- gate  out  1  generator enable
- step_idx  out  3  index of the step currently sounding
- step_tick  out  1  one-cycle pulse on each step load

## Operation
- Pattern RAM: STEPS x 9-bit registers.
  - Reset sets every entry to 9'h100 (rest).
  - A write with wr_en=1 takes effect on the next clk edge, at any time.
- Note decode: note 0..10 gives note_sw = 1<<note. Note 11..15 is treated as a rest.
- Rest step: note_sw=0, gate=0. octave and wave_sel still load from the word.
- Effective step length L = max(tempo_div, 8) cycles.
- Gap length G = L>>3 cycles.
- FSM states:
  - IDLE: outputs zero, counter=0, step_idx=0.
  - LOAD: a single cycle. Registers outputs from RAM[step_idx], pulses step_tick, clears the counter.
  - PLAY: counter increments. In the final cycle of the step (counter=L-2), step_idx advances and the FSM goes to LOAD.
  - GAP: present only with the macro; see Configuration.
- State transitions:
  - IDLE→LOAD when run=1.
  - Any state→IDLE when run=0.
  - run=0 takes effect on the next edge: gate=0, note_sw=0, step_idx=0.
- Step advance: if step_idx ≥ seq_len, the next index is 0; otherwise it is step_idx+1. A seq_len reduced mid-play therefore wraps at the next boundary.
- A write to the currently sounding step is heard only at that step's next LOAD. Outputs are registered only in LOAD.
- Simultaneous write and LOAD of the same address: LOAD reads the old word.
- A tempo_div change is sampled at each LOAD; the current step's length does not change.

## Timing
- Reset value of every output is 0. step_idx=0, FSM in IDLE.
- Start latency: run sampled high at edge k → LOAD at edge k+1. Outputs and step_tick are valid after edge k+1.
- Step period is exactly L cycles, counted LOAD to LOAD.
- step_tick is high for 1 cycle per step, coincident with the new outputs.
- rst has priority over run and wr_en.
- Reset mid-play returns to IDLE and clears the pattern.

## Configuration
- NOTE_SEQUENCER_GAP_EN defined:
  - PLAY→GAP when counter=L-G-1.
  - gate=0 for the last G cycles of every step (staccato articulation). note_sw, octave and wave_sel hold through the gap.
  - GAP→LOAD at the same step boundary, so the period is still L.
- Undefined: no GAP state. Gate stays high continuously across consecutive non-rest steps (legato).

## Structure
- Shared package synth_pkg holds:
  - step-word field offsets and widths
  - wave codes WAVE_SINE/TRI/SQR/SAW
  - rest word 9'h100
  - FSM state enum {IDLE, LOAD, PLAY, GAP}
  - MIN_STEP_LEN = 8
- One natural sub-module, step_ram: the pattern register file with a synchronous write port and a combinational read port.

## Test plan
- Reset then run=1: step_tick is at edge 2. With entry 0 holding the rest word, outputs are all 0 and gate=0.
- Write step0={0,2'd1,2'd2,4'd3}, seq_len=0, tempo_div=16, run=1:
  - note_sw=11'h008, octave=2, wave_sel=1, gate=1.
  - step_tick every 16 cycles.
- seq_len=2 with three distinct steps: step_idx sequence 0,1,2,0. Change seq_len to 0 while at step 2 → next index is 0 and stays 0.
- tempo_div=3: step period is 8 cycles (clamped). tempo_div=0: step period is also 8.
- Write note=12 to step 1: when step 1 loads, note_sw=0 and gate=0. A write to step 0 while it sounds is heard only on the next wrap.
- With NOTE_SEQUENCER_GAP_EN and tempo_div=64: gate is low for cycles 56–63 of each step and high for the rest. Without the macro, gate stays 1 throughout.
